hdu_count_table: RTL and testbench

//  Parametrised hazard-detection unit for the vertex-update pipeline. It keeps a
//  per-address outstanding-access counter, not a 1-bit flag. Each issued read

---
 rtl/hdu_count_table.sv | 162 ++++++++++++++++
 tb/tb_hdu_count_table.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdu_count_table.sv
// Hazard detection unit with per-address outstanding-access counters.
// Three-cycle pipeline: table read, update with bypass, registered result.
module hdu_count_table #(
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 4,
  parameter int OCC_W      = 16,
  parameter bit INIT_SWEEP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  output logic              flag_valid,
  output logic              flag,
  output logic [CNT_W-1:0]  flag_cnt,
  output logic [OCC_W-1:0]  occupancy,
  output logic              init_done,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep;
  logic [CNT_W-1:0]  mem [DEPTH];

  logic              rd_fire;
  logic              wr_fire;

  logic              s1_rv;
  logic [ADDR_W-1:0] s1_ra;
  logic [CNT_W-1:0]  s1_rd;
  logic              s1_wv;
  logic [ADDR_W-1:0] s1_wa;
  logic [CNT_W-1:0]  s1_wd;

  // Write-backs from the previous cycle, not yet visible to the table read
  logic              bp0_v;
  logic [ADDR_W-1:0] bp0_a;
  logic [CNT_W-1:0]  bp0_d;
  logic              bp1_v;
  logic [ADDR_W-1:0] bp1_a;
  logic [CNT_W-1:0]  bp1_d;

  logic              same;
  logic [CNT_W-1:0]  r_cur;
  logic [CNT_W-1:0]  w_cur;
  logic [CNT_W-1:0]  w_new;
  logic [CNT_W-1:0]  r_seen;
  logic [CNT_W-1:0]  r_new;
  logic              udf;
  logic              ovf;
  logic              inc;
  logic              dec;

  assign rd_ready = init_done;
  assign rd_fire  = rd_valid && init_done;
  assign wr_fire  = wr_valid && init_done;

  always_comb begin
    r_cur = s1_rd;
    if (bp0_v && bp0_a == s1_ra)
      r_cur = bp0_d;
    else if (bp1_v && bp1_a == s1_ra)
      r_cur = bp1_d;
    w_cur = s1_wd;
    if (bp0_v && bp0_a == s1_wa)
      w_cur = bp0_d;
    else if (bp1_v && bp1_a == s1_wa)
      w_cur = bp1_d;
  end

  // Retire applies before a same-cycle read of the same address
  always_comb begin
    same   = s1_rv && s1_wv && (s1_ra == s1_wa);
    udf    = s1_wv && (w_cur == '0);
    w_new  = (w_cur == '0) ? '0 : w_cur - CNT_W'(1);
    r_seen = same ? w_new : r_cur;
    ovf    = s1_rv && (r_seen == CMAX);
    r_new  = (r_seen == CMAX) ? CMAX : r_seen + CNT_W'(1);
    inc    = s1_rv && !ovf;
    dec    = s1_wv && !udf;
  end

  always_ff @(posedge clk) begin
    s1_rd <= mem[rd_addr];
    s1_wd <= mem[wr_addr];
    if (state == INIT) begin
      mem[sweep] <= '0;
    end else begin
      if (s1_rv)
        mem[s1_ra] <= r_new;
      if (s1_wv && !same)
        mem[s1_wa] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_SWEEP ? INIT : RUN;
      sweep      <= '0;
      init_done  <= 1'b0;
      s1_rv      <= 1'b0;
      s1_ra      <= '0;
      s1_wv      <= 1'b0;
      s1_wa      <= '0;
      bp0_v      <= 1'b0;
      bp0_a      <= '0;
      bp0_d      <= '0;
      bp1_v      <= 1'b0;
      bp1_a      <= '0;
      bp1_d      <= '0;
      flag_valid <= 1'b0;
      flag       <= 1'b0;
      flag_cnt   <= '0;
      occupancy  <= '0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          sweep <= sweep + ADDR_W'(1);
          if (&sweep)
            state <= RUN;
        end
        RUN: state <= RUN;
        default: state <= INIT;
      endcase
      init_done  <= (state == RUN);
      s1_rv      <= rd_fire;
      s1_ra      <= rd_addr;
      s1_wv      <= wr_fire;
      s1_wa      <= wr_addr;
      bp0_v      <= s1_rv;
      bp0_a      <= s1_ra;
      bp0_d      <= r_new;
      bp1_v      <= s1_wv && !same;
      bp1_a      <= s1_wa;
      bp1_d      <= w_new;
      flag_valid <= s1_rv;
      flag       <= s1_rv && (r_seen != '0);
      flag_cnt   <= s1_rv ? r_seen : '0;
      unique case ({inc, dec})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (ovf)
        err_ovf <= 1'b1;
      if (udf)
        err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdu_count_table.sv
// Bench for hdu_count_table: directed vector table, init/reset sequences
// and a random run against a sequential reference counter model.
module tb_hdu_count_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rd_addr = '0;
  logic       rd_valid = 1'b0;
  logic       rd_ready;
  logic [3:0] wr_addr = '0;
  logic       wr_valid = 1'b0;
  logic       flag_valid;
  logic       flag;
  logic [1:0] flag_cnt;
  logic [15:0] occupancy;
  logic       init_done;
  logic       err_ovf;
  logic       err_udf;

  hdu_count_table #(
    .ADDR_W(4), .CNT_W(2), .OCC_W(16), .INIT_SWEEP(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_addr(wr_addr), .wr_valid(wr_valid),
    .flag_valid(flag_valid), .flag(flag), .flag_cnt(flag_cnt),
    .occupancy(occupancy), .init_done(init_done),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fv;
    bit f;
    int cnt;
    int occ;
  } exp_t;

  typedef struct {
    bit rv;
    int ra;
    bit wv;
    int wa;
    bit fv;
    bit f;
    int cnt;
    int occ;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  exp_t p1, p2;
  bit   p1_live = 0;
  bit   p2_live = 0;

  int cnt_m [16];
  int occ_m;
  bit ovf_m;
  bit udf_m;

  vec_t tbl [18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit rv, input int ra, input bit wv,
                      input int wa, input exp_t e);
    @(negedge clk);
    if (p2_live) begin
      check("flag_valid", int'(flag_valid), int'(p2.fv));
      if (p2.fv) begin
        check("flag", int'(flag), int'(p2.f));
        check("flag_cnt", int'(flag_cnt), p2.cnt);
      end
      check("occupancy", int'(occupancy), p2.occ);
    end
    p2 = p1;
    p2_live = p1_live;
    p1 = e;
    p1_live = 1'b1;
    rd_valid = rv;
    rd_addr  = 4'(ra);
    wr_valid = wv;
    wr_addr  = 4'(wa);
  endtask

  task automatic model_op(input bit rv, input int ra, input bit wv,
                          input int wa, output exp_t e);
    int seen;
    e.fv = rv;
    e.f = 1'b0;
    e.cnt = 0;
    if (wv) begin
      if (cnt_m[wa] == 0) udf_m = 1'b1;
      else begin
        cnt_m[wa]--;
        occ_m--;
      end
    end
    if (rv) begin
      seen = cnt_m[ra];
      e.f = (seen != 0);
      e.cnt = seen;
      if (seen == 3) ovf_m = 1'b1;
      else begin
        cnt_m[ra]++;
        occ_m++;
      end
    end
    e.occ = occ_m;
  endtask

  task automatic do_reset();
    int n;
    bit bad;
    @(negedge clk);
    rst = 1'b1;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check("rst flag_valid", int'(flag_valid), 0);
    check("rst flag", int'(flag), 0);
    check("rst flag_cnt", int'(flag_cnt), 0);
    check("rst occupancy", int'(occupancy), 0);
    check("rst err_ovf", int'(err_ovf), 0);
    check("rst err_udf", int'(err_udf), 0);
    check("rst init_done", int'(init_done), 0);
    check("rst rd_ready", int'(rd_ready), 0);
    rst = 1'b0;
    // Traffic during the sweep must be dropped
    rd_valid = 1'b1;
    rd_addr  = 4'h3;
    wr_valid = 1'b1;
    wr_addr  = 4'h9;
    n = 0;
    bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!init_done && rd_ready) bad = 1'b1;
      if (init_done) break;
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    check("init latency", n, 17);
    check("rd_ready in INIT", int'(bad), 0);
    p1_live = 1'b0;
    p2_live = 1'b0;
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    occ_m = 0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
    repeat (2) @(negedge clk);
    check("post-init occupancy", int'(occupancy), 0);
    check("post-init err_udf", int'(err_udf), 0);
    check("post-init flag_valid", int'(flag_valid), 0);
  endtask

  task automatic run_random(input int cycles);
    exp_t e;
    bit rv, wv;
    int ra, wa;
    for (int i = 0; i < cycles; i++) begin
      rv = ($urandom_range(0, 99) < 55);
      wv = ($urandom_range(0, 99) < 55);
      ra = $urandom_range(0, 15);
      wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15);
      model_op(rv, ra, wv, wa, e);
      step(rv, ra, wv, wa, e);
    end
  endtask

  initial begin
    exp_t e;
    tbl[0]  = '{1, 3, 0, 0, 1, 0, 0, 1};
    tbl[1]  = '{1, 3, 0, 0, 1, 1, 1, 2};
    tbl[2]  = '{1, 3, 0, 0, 1, 1, 2, 3};
    tbl[3]  = '{1, 3, 0, 0, 1, 1, 3, 3};
    tbl[4]  = '{1, 3, 0, 0, 1, 1, 3, 3};
    tbl[5]  = '{1, 5, 0, 0, 1, 0, 0, 4};
    tbl[6]  = '{1, 5, 1, 5, 1, 0, 0, 4};
    tbl[7]  = '{1, 5, 0, 0, 1, 1, 1, 5};
    tbl[8]  = '{0, 0, 1, 3, 0, 0, 0, 4};
    tbl[9]  = '{1, 3, 0, 0, 1, 1, 2, 5};
    tbl[10] = '{0, 0, 1, 9, 0, 0, 0, 5};
    tbl[11] = '{1, 9, 0, 0, 1, 0, 0, 6};
    tbl[12] = '{1, 7, 1, 5, 1, 0, 0, 6};
    tbl[13] = '{1, 5, 0, 0, 1, 1, 1, 7};
    tbl[14] = '{0, 0, 1, 7, 0, 0, 0, 6};
    tbl[15] = '{1, 7, 0, 0, 1, 0, 0, 7};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 7};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 7};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      e.fv  = tbl[i].fv;
      e.f   = tbl[i].f;
      e.cnt = tbl[i].cnt;
      e.occ = tbl[i].occ;
      step(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, e);
    end
    @(negedge clk);
    check("table err_ovf", int'(err_ovf), 1);
    check("table err_udf", int'(err_udf), 1);
    check("table occupancy", int'(occupancy), 7);

    // Reset with operations in flight, then random traffic
    do_reset();
    run_random(4000);
    rd_valid = 1'b1;
    rd_addr  = 4'h2;
    wr_valid = 1'b1;
    wr_addr  = 4'h2;
    do_reset();
    run_random(5000);
    e = '{0, 0, 0, occ_m};
    step(0, 0, 0, 0, e);
    step(0, 0, 0, 0, e);
    step(0, 0, 0, 0, e);
    check("random err_ovf", int'(err_ovf), int'(ovf_m));
    check("random err_udf", int'(err_udf), int'(udf_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
